// File: rtl/and6_bist_ctrl_pkg.sv
// Shared definitions for the AND-block BIST controller: FSM encoding and
// the vector-count helper.
package and6_bist_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRIVE  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Number of (a, b) pairs swept for operand width w.
  function automatic int unsigned num_vectors(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module bist_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != MAX))
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/and6_bist_ctrl.sv
// Sweeps every (a, b) pair into a combinational AND block, samples y after a
// programmable settle time and tracks mismatches against a & b.
module and6_bist_ctrl
  import and6_bist_ctrl_pkg::*;
#(
  parameter int W             = 6,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic [W-1:0]     y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2*W-1:0]   first_fail_idx
);

  localparam int IW  = 2 * W;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IW-1:0]  LAST_IDX    = '1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]   ff_q, ff_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [SCW-1:0]  settle_cnt;
  logic            settle_last, launch, mismatch, in_check;

  assign launch      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_check    = (state_q == ST_CHECK);
  assign mismatch    = (y_in != (a_q & b_q));
  assign settle_last = (state_q == ST_SETTLE) && (settle_cnt == SETTLE_LAST);

  bist_sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (launch),
    .inc_i (in_check && mismatch),
    .cnt_o (err_count)
  );

  // Held at zero outside SETTLE so every vector starts its wait from 0.
  bist_sat_counter #(.WIDTH(SCW)) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q != ST_SETTLE) || settle_last),
    .inc_i (state_q == ST_SETTLE),
    .cnt_o (settle_cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          ff_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        a_d     = idx_q[IW-1:W];
        b_d     = idx_q[W-1:0];
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_last) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch && (err_count == '0)) ff_d = idx_q;
        if (idx_q == LAST_IDX) begin
          // err_count is sticky once nonzero, so this is the final verdict.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count == '0) && !mismatch;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_and6_bist_ctrl.sv
// Directed bench: default-size controller around a switchable DUT model
// (correct / y[0] stuck low / OR), plus a W=2, SETTLE_CYCLES=3 instance.
module tb_and6_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [5:0]  a_out, b_out, y_in;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [11:0] first_fail_idx;

  logic [1:0]  a2, b2, y2;
  logic        busy2, done2, pass2;
  logic [7:0]  err2;
  logic [3:0]  ff2;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd1:    y_in = (a_out & b_out) & 6'b111110;
      2'd2:    y_in = a_out | b_out;
      default: y_in = a_out & b_out;
    endcase
  end

  assign y2 = a2 & b2;

  and6_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  and6_bist_ctrl #(.W(2), .SETTLE_CYCLES(3), .ERR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_idx(ff2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a",    32'(a_out), 32'h0);
    check("rst_b",    32'(b_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_err",  32'(err_count), 32'h0);
    check("rst_ff",   32'(first_fail_idx), 32'h0);
    rst_n = 1'b1;

    // Correct DUT, with a stray start pulse mid-sweep that must be ignored.
    pulse_start();
    check("s1_busy_rise", 32'(busy), 32'h1);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      start = (n == 100);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("s1_cycles", 32'(n), 32'd12288);
    check("s1_busy",   32'(busy), 32'h0);
    check("s1_pass",   32'(pass), 32'h1);
    check("s1_err",    32'(err_count), 32'h0);
    check("s1_a_last", 32'(a_out), 32'h3f);
    check("s1_b_last", 32'(b_out), 32'h3f);

    // Restart from DONE with y[0] stuck at 0.
    repeat (4) @(negedge clk);
    check("s1_done_hold", 32'(done), 32'h1);
    mode = 2'd1;
    pulse_start();
    check("s2_done_clr", 32'(done), 32'h0);
    check("s2_pass_clr", 32'(pass), 32'h0);
    check("s2_busy",     32'(busy), 32'h1);
    wait_done(n);
    check("s2_cycles", 32'(n), 32'd12288);
    check("s2_err",    32'(err_count), 32'd255);
    check("s2_ff",     32'(first_fail_idx), 32'h041);
    check("s2_pass",   32'(pass), 32'h0);

    // OR instead of AND.
    mode = 2'd2;
    pulse_start();
    check("s3_err_clr", 32'(err_count), 32'h0);
    wait_done(n);
    check("s3_cycles", 32'(n), 32'd12288);
    check("s3_err",    32'(err_count), 32'd255);
    check("s3_ff",     32'(first_fail_idx), 32'h001);
    check("s3_pass",   32'(pass), 32'h0);

    // Asynchronous reset in the middle of a failing sweep.
    pulse_start();
    repeat (500) @(negedge clk);
    check("s4_pre_err_nz", 32'(err_count != 8'd0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_a",    32'(a_out), 32'h0);
    check("ar_b",    32'(b_out), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    check("ar_pass", 32'(pass), 32'h0);
    check("ar_err",  32'(err_count), 32'h0);
    check("ar_ff",   32'(first_fail_idx), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    mode = 2'd0;
    pulse_start();
    wait_done(n);
    check("s5_cycles", 32'(n), 32'd12288);
    check("s5_pass",   32'(pass), 32'h1);
    check("s5_err",    32'(err_count), 32'h0);

    // Small instance: 16 vectors x 5 cycles.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("w2_cycles", 32'(n), 32'd80);
    check("w2_a",      32'(a2), 32'h3);
    check("w2_b",      32'(b2), 32'h3);
    check("w2_pass",   32'(pass2), 32'h1);
    check("w2_err",    32'(err2), 32'h0);
    check("w2_busy",   32'(busy2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
